// File: rtl/line_draw_pkg.sv
// Screen geometry and state encoding shared by the line-drawing datapath and
// the framebuffer write queue.
package line_draw_pkg;

    localparam int ADDR_W = 17;

    localparam logic [8:0]        SCREEN_W  = 9'd320;
    localparam logic [7:0]        SCREEN_H  = 8'd240;
    localparam logic [ADDR_W-1:0] LAST_ADDR = 17'd76799;

    typedef enum logic {RUN, CLEAR} state_t;

    // y*320 + x built from two shifts so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [8:0] x, input logic [7:0] y);
        return ({9'd0, y} << 8) + ({9'd0, y} << 6) + {8'd0, x};
    endfunction

endpackage

// File: rtl/plot_write_queue_if.sv
// Plot request stream, clear request and framebuffer write port of the queue.
interface plot_write_queue_if #(parameter int COLOR_W = 3);

    logic                            plot;
    logic [8:0]                      plot_x;
    logic [7:0]                      plot_y;
    logic [COLOR_W-1:0]              plot_color;
    logic                            plot_ready;
    logic                            clear;
    logic [COLOR_W-1:0]              clear_color;
    logic                            mem_grant;
    logic                            mem_we;
    logic [line_draw_pkg::ADDR_W-1:0] mem_addr;
    logic [COLOR_W-1:0]              mem_data;

    modport master (
        output plot, plot_x, plot_y, plot_color, clear, clear_color, mem_grant,
        input  plot_ready, mem_we, mem_addr, mem_data
    );

    modport slave (
        input  plot, plot_x, plot_y, plot_color, clear, clear_color, mem_grant,
        output plot_ready, mem_we, mem_addr, mem_data
    );

endinterface

// File: rtl/plot_fifo.sv
// Synchronous FIFO; the head entry is visible on dout while not empty.
module plot_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/plot_write_queue.sv
// Range-checks plot strobes, queues their framebuffer addresses and drains
// them on granted slots; also sweeps the whole screen on a clear request.
module plot_write_queue
    import line_draw_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int COLOR_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    plot_write_queue_if.slave  bus,
    output logic [7:0]         dropped_count,
    output logic               idle
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + COLOR_W;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t              state;
    logic                clear_pending;
    logic [ADDR_W-1:0]   clear_addr;
    logic [COLOR_W-1:0]  clear_color_q;

    logic                in_range;
    logic                accept;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [ENTRY_W-1:0]  head;
    logic [ADDR_W-1:0]   plot_addr;

    assign in_range  = (bus.plot_x < SCREEN_W) && (bus.plot_y < SCREEN_H);
    assign plot_addr = pixel_addr(bus.plot_x, bus.plot_y);

    // A full FIFO refuses even when it pops this cycle, keeping ready off the grant path.
    assign bus.plot_ready = !reset && (state == RUN) && !clear_pending && !fifo_full;
    assign accept         = bus.plot && bus.plot_ready;
    assign push           = accept && in_range;
    assign pop            = !reset && (state == RUN) && !fifo_empty && bus.mem_grant;

    assign idle = fifo_empty && (state == RUN) && !clear_pending;

    plot_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({plot_addr, bus.plot_color}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_data = '0;
        if (state == CLEAR) begin
            bus.mem_we   = bus.mem_grant && !reset;
            bus.mem_addr = clear_addr;
            bus.mem_data = clear_color_q;
        end else if (!fifo_empty) begin
            bus.mem_we   = pop;
            bus.mem_addr = head[ENTRY_W-1:COLOR_W];
            bus.mem_data = head[COLOR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            clear_pending <= 1'b0;
            clear_addr    <= '0;
            dropped_count <= '0;
        end else begin
            if (accept && !in_range) dropped_count <= sat_inc8(dropped_count);
            case (state)
                RUN: begin
                    if (clear_pending && (fifo_count == '0)) begin
                        state         <= CLEAR;
                        clear_addr    <= '0;
                        clear_pending <= 1'b0;
                    end else if (bus.clear && !clear_pending) begin
                        clear_pending <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (bus.mem_grant) begin
                        clear_addr <= clear_addr + ADDR_W'(1);
                        if (clear_addr == LAST_ADDR) state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Fill colour is captured only when the request is actually taken.
    always_ff @(posedge clk) begin
        if (!reset && (state == RUN) && !clear_pending && bus.clear)
            clear_color_q <= bus.clear_color;
    end

endmodule

// File: tb/tb_plot_write_queue.sv
// Bench for plot_write_queue: vector table, corner sequences and a queue-based model.
module tb_plot_write_queue;
    import line_draw_pkg::*;

    localparam int DEPTH   = 4;
    localparam int COLOR_W = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dropped_count;
    logic       idle;

    plot_write_queue_if #(.COLOR_W(COLOR_W)) bus();

    plot_write_queue #(.DEPTH(DEPTH), .COLOR_W(COLOR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .dropped_count (dropped_count),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    typedef struct {
        bit p; int x; int y; int c; bit g;
        bit r; bit we; bit chk_ad; int addr; int data; int drop; bit idl;
    } vec_t;
    vec_t vecs[12];

    typedef struct { int addr; int color; } ent_t;
    ent_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input bit p, input int x, input int y, input int c,
                         input bit g, input bit clr, input int cc);
        bus.plot        = p;
        bus.plot_x      = 9'(x);
        bus.plot_y      = 8'(y);
        bus.plot_color  = COLOR_W'(c);
        bus.mem_grant   = g;
        bus.clear       = clr;
        bus.clear_color = COLOR_W'(cc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 0);
        repeat (2) tick();
        @(negedge clk);
        check("rst_ready_low", bus.plot_ready, 0);
        check("rst_we_low", bus.mem_we, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", bus.plot_ready, 1);
        check("rst_we", bus.mem_we, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_data", bus.mem_data, 0);
        check("rst_dropped", dropped_count, 0);
        check("rst_idle", idle, 1);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_n, bad, ready_hi, exp_a, bad_grant, drop_m;
        bit done, reached, g, p, exp_ready, exp_we;
        int x, y, c;

        vecs[0]  = '{1, 10,  5,  3, 1,  1, 0, 0, 0,     0, 0, 1};
        vecs[1]  = '{0, 0,   0,  0, 1,  1, 1, 1, 1610,  3, 0, 0};
        vecs[2]  = '{0, 0,   0,  0, 0,  1, 0, 0, 0,     0, 0, 1};
        vecs[3]  = '{1, 320, 0,  0, 0,  1, 0, 0, 0,     0, 0, 1};
        vecs[4]  = '{1, 0,   240,0, 0,  1, 0, 0, 0,     0, 1, 1};
        vecs[5]  = '{1, 319, 239,7, 0,  1, 0, 0, 0,     0, 2, 1};
        vecs[6]  = '{0, 0,   0,  0, 0,  1, 0, 1, 76799, 7, 2, 0};
        vecs[7]  = '{0, 0,   0,  0, 1,  1, 1, 1, 76799, 7, 2, 0};
        vecs[8]  = '{1, 0,   0,  1, 1,  1, 0, 0, 0,     0, 2, 1};
        vecs[9]  = '{1, 1,   1,  2, 1,  1, 1, 1, 0,     1, 2, 0};
        vecs[10] = '{0, 0,   0,  0, 1,  1, 1, 1, 321,   2, 2, 0};
        vecs[11] = '{0, 0,   0,  0, 0,  1, 0, 0, 0,     0, 2, 1};

        do_reset();

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].p, vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].g, 0, 0);
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), bus.plot_ready, vecs[i].r);
            check($sformatf("vec%0d_we", i), bus.mem_we, vecs[i].we);
            if (vecs[i].chk_ad) begin
                check($sformatf("vec%0d_addr", i), bus.mem_addr, vecs[i].addr);
                check($sformatf("vec%0d_data", i), bus.mem_data, vecs[i].data);
            end
            check($sformatf("vec%0d_dropped", i), dropped_count, vecs[i].drop);
            check($sformatf("vec%0d_idle", i), idle, vecs[i].idl);
            tick();
        end

        // Fill the FIFO with grant held low, then drain in order.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, i, 0, i, 0, 0, 0);
            @(negedge clk);
            check($sformatf("fill%0d_ready", i), bus.plot_ready, (i < 4) ? 1 : 0);
            tick();
        end
        drive(1, 100, 0, 7, 1, 0, 0);
        @(negedge clk);
        check("full_pop_ready", bus.plot_ready, 0);
        check("drain0_we", bus.mem_we, 1);
        check("drain0_addr", bus.mem_addr, 0);
        check("drain0_data", bus.mem_data, 0);
        tick();
        for (int i = 1; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            @(negedge clk);
            check($sformatf("drain%0d_we", i), bus.mem_we, 1);
            check($sformatf("drain%0d_addr", i), bus.mem_addr, i);
            check($sformatf("drain%0d_data", i), bus.mem_data, i);
            tick();
        end
        @(negedge clk);
        check("drained_we", bus.mem_we, 0);
        check("drained_idle", idle, 1);
        tick();

        // Drop counter saturation.
        do_reset();
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) drive(1, $urandom_range(320, 511), $urandom_range(0, 255), 1, 1, 0, 0);
            else            drive(1, $urandom_range(0, 511), $urandom_range(240, 255), 1, 1, 0, 0);
            @(negedge clk);
            if (bus.mem_we) bad++;
            if (i == 254) check("drop_254", dropped_count, 254);
            tick();
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        check("drop_sat", dropped_count, 255);
        check("drop_no_we", bad, 0);
        tick();

        // Randomized traffic against a queue model.
        do_reset();
        q.delete();
        drop_m = 0;
        for (int i = 0; i < 2000; i++) begin
            p = ($urandom_range(0, 3) != 0);
            x = ($urandom_range(0, 4) == 0) ? $urandom_range(320, 511) : $urandom_range(0, 319);
            y = ($urandom_range(0, 4) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 239);
            c = $urandom_range(0, 7);
            g = (i < 1000) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            drive(p, x, y, c, g, 0, 0);
            @(negedge clk);
            exp_ready = (q.size() < DEPTH);
            exp_we    = (q.size() > 0) && g;
            check("rnd_ready", bus.plot_ready, exp_ready);
            check("rnd_we", bus.mem_we, exp_we);
            if (exp_we) begin
                check("rnd_addr", bus.mem_addr, q[0].addr);
                check("rnd_data", bus.mem_data, q[0].color);
            end
            check("rnd_dropped", dropped_count, drop_m);
            check("rnd_idle", idle, (q.size() == 0));
            if (exp_we) void'(q.pop_front());
            if (p && exp_ready) begin
                if (x < 320 && y < 240) q.push_back('{y * 320 + x, c});
                else if (drop_m < 255) drop_m++;
            end
            tick();
        end

        // Full clear behind two queued plots.
        do_reset();
        drive(1, 5, 0, 1, 0, 0, 0);
        tick();
        drive(1, 6, 0, 2, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 5);
        @(negedge clk);
        check("clr_pulse_idle", idle, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        wr_n = 0; bad = 0; ready_hi = 0; done = 0;
        for (int cyc = 0; cyc < 80000 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) check("clr_ready_low", bus.plot_ready, 0);
            if (bus.plot_ready) ready_hi++;
            if (bus.mem_we) begin
                if (wr_n == 0) begin
                    check("clr_q0_addr", bus.mem_addr, 5);
                    check("clr_q0_data", bus.mem_data, 1);
                end else if (wr_n == 1) begin
                    check("clr_q1_addr", bus.mem_addr, 6);
                    check("clr_q1_data", bus.mem_data, 2);
                end else if (bus.mem_addr !== 17'(wr_n - 2) || bus.mem_data !== 3'd5) begin
                    bad++;
                end
                wr_n++;
                if (wr_n == 76802) done = 1;
            end
            tick();
        end
        check("clr_write_count", wr_n, 76802);
        check("clr_sweep_errors", bad, 0);
        check("clr_ready_during", ready_hi, 0);
        @(negedge clk);
        check("clr_done_ready", bus.plot_ready, 1);
        check("clr_done_idle", idle, 1);
        check("clr_done_we", bus.mem_we, 0);
        tick();

        // Random grant during clear, then reset at address 1000.
        do_reset();
        drive(1, 400, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 6);
        tick();
        exp_a = 0; bad = 0; bad_grant = 0; ready_hi = 0; reached = 0;
        for (int cyc = 0; cyc < 6000 && !reached; cyc++) begin
            g = $urandom_range(0, 1);
            drive(0, 0, 0, 0, g, 0, 0);
            @(negedge clk);
            if (bus.plot_ready) ready_hi++;
            if (bus.mem_we) begin
                if (!g) bad_grant++;
                if (bus.mem_addr !== 17'(exp_a) || bus.mem_data !== 3'd6) bad++;
                exp_a++;
            end
            tick();
            if (exp_a == 1000) reached = 1;
        end
        check("rg_reached_1000", reached, 1);
        check("rg_sequence_errors", bad, 0);
        check("rg_we_without_grant", bad_grant, 0);
        check("rg_ready_during", ready_hi, 0);
        check("rg_dropped_before_reset", dropped_count, 1);
        reset = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        check("midrst_we_in_reset", bus.mem_we, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_we", bus.mem_we, 0);
        check("midrst_ready", bus.plot_ready, 1);
        check("midrst_idle", idle, 1);
        check("midrst_dropped", dropped_count, 0);
        tick();
        drive(1, 2, 3, 4, 1, 0, 0);
        @(negedge clk);
        check("post_rst_we_empty", bus.mem_we, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        check("post_rst_we", bus.mem_we, 1);
        check("post_rst_addr", bus.mem_addr, 962);
        check("post_rst_data", bus.mem_data, 4);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/plot_write_queue.md
# plot_write_queue

Sink for the pixel-plot stream produced by the line-drawing datapath. Accepts (x, y, color) plot strobes, range-checks them, converts each to a linear framebuffer address, buffers it in a small FIFO, and drains it to the framebuffer write port whenever the memory arbiter grants a slot. It also performs a full-screen clear on request, so the line-drawing FSM never has to wait on framebuffer timing.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- COLOR_W, 3, pixel colour width

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- plot  in  1  plot request valid
- plot_x  in  9  pixel column
- plot_y  in  8  pixel row
- plot_color  in  COLOR_W  pixel colour
- plot_ready  out  1  request accepted this cycle when plot && plot_ready
- clear  in  1  one-cycle clear-screen request
- clear_color  in  COLOR_W  fill colour, sampled when clear is asserted
- mem_grant  in  1  framebuffer write slot available this cycle
- mem_we  out  1  write strobe
- mem_addr  out  17  linear address, y*320 + x
- mem_data  out  COLOR_W  write data
- dropped_count  out  8  saturating count of out-of-range requests
- idle  out  1  FIFO empty, in RUN, no clear pending

## Operation
- Range check at acceptance: x < 320 and y < 240. An out-of-range request is still handshaken (consumed) but not queued; dropped_count increments and saturates at 255.
- Address: (y<<8) + (y<<6) + x, computed with 17-bit unsigned arithmetic. The maximum is 76799.
- FIFO stores {addr, color}. Read and write pointers wrap modulo DEPTH. The occupancy count is DEPTH-width+1 bits.
- plot_ready = state==RUN && !clear_pending && count != DEPTH.
  - plot_ready does not depend on mem_grant.
  - A full FIFO that is popping this cycle still refuses a push.
- Push and pop in the same cycle leave the count unchanged.
- State machine (RUN, CLEAR):
  - RUN: mem_we = (count != 0) && mem_grant. mem_addr and mem_data come from the FIFO head. A write pops the head.
  - A clear pulse sets clear_pending and latches clear_color.
  - RUN -> CLEAR when clear_pending is set and count == 0. On that transition, clear_addr <= 0 and clear_pending is cleared.
  - CLEAR: plot_ready = 0. mem_we = mem_grant, mem_addr = clear_addr, mem_data = latched colour. clear_addr increments on each granted write.
  - CLEAR -> RUN after the granted write at address 76799.
  - clear asserted while in CLEAR, or while clear_pending is already set, is ignored.
- mem_we is never asserted without mem_grant in the same cycle.

## Timing
- Reset values: plot_ready 0 during reset, 1 in the first cycle after it. mem_we 0, mem_addr 0, mem_data 0, dropped_count 0, idle 1. State is RUN, FIFO is empty, clear_pending is 0.
- Reset mid-operation discards all queued entries and any clear in progress. No write is issued in the cycle after reset deasserts.
- Latency: a request accepted at edge N is visible at the FIFO head after edge N. The earliest mem_we is the cycle after acceptance, with mem_grant high.
- Throughput: one plot per cycle in and one write per granted cycle out.
- A full clear takes exactly 76800 granted cycles after the FIFO drains.
- idle deasserts in the cycle after an accepted in-range plot or a clear pulse.

## Structure
- Shared package line_draw_pkg:
  - SCREEN_W=320, SCREEN_H=240, ADDR_W=17, LAST_ADDR=76799
  - state typedef {RUN, CLEAR}
  - The line-drawing datapath uses the same screen constants.
- Sub-module plot_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised by DEPTH and data width. The top level holds the range check, the address arithmetic, the FSM and the drop counter.

## Test plan
- Reset, then plot (10,5,color 3) with mem_grant=1 -> one cycle later mem_we=1, mem_addr=1610, mem_data=3. idle returns to 1 after the pop.
- mem_grant=0, push 5 in-range plots with DEPTH=4 -> plot_ready goes 0 after the 4th. Raising mem_grant drains the entries in order, one per cycle.
- Plot (320,0) then (0,240) -> no mem_we, dropped_count=2. Drive 300 out-of-range plots -> dropped_count holds at 255.
- Queue 2 plots, pulse clear with clear_color=5, mem_grant=1 -> plot_ready=0 immediately. The 2 queued writes go first, then addresses 0..76799 with data 5, then the block is back in RUN with plot_ready=1.
- During CLEAR, toggle mem_grant pseudo-randomly -> no address is skipped or repeated, and mem_we only appears when mem_grant is high.
- Assert reset mid-clear at address 1000 -> next cycle mem_we=0, state RUN, FIFO empty, dropped_count=0.
